// File: rtl/vocoder_frame_ctrl_pkg.sv
// Shared pitch-shifter definitions: frame controller state encoding,
// default datapath widths and pipeline latencies.
package vocoder_frame_ctrl_pkg;

  localparam int unsigned PHASE_WIDTH_DEF = 24;
  localparam int unsigned K_WIDTH_DEF     = 11;
  localparam int unsigned F_WIDTH_DEF     = K_WIDTH_DEF + 21 + 6;
  localparam int unsigned RAM_LATENCY_DEF = 2;
  localparam int unsigned VOC_LATENCY_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } frame_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold a down-counter load value of max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vocoder_frame_ctrl_cycle_counter.sv
// Loadable down-counter that saturates at zero and flags terminal count.
module vocoder_frame_ctrl_cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/vocoder_frame_ctrl.sv
// Per-frame sequencer: reads current/previous phase from the ping-pong RAM,
// issues one vocoder request and latches the returned fundamental.
module vocoder_frame_ctrl
  import vocoder_frame_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int unsigned K_WIDTH     = K_WIDTH_DEF,
  parameter int unsigned F_WIDTH     = F_WIDTH_DEF,
  parameter int unsigned RAM_LATENCY = RAM_LATENCY_DEF,
  parameter int unsigned VOC_LATENCY = VOC_LATENCY_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   frame_done,
  input  logic [K_WIDTH-1:0]     frame_k_max,
  output logic                   write_bank,
  output logic                   phase_rd_en,
  output logic [K_WIDTH-1:0]     phase_addr,
  input  logic [PHASE_WIDTH-1:0] cur_phase,
  input  logic [PHASE_WIDTH-1:0] last_phase_in,
  output logic [PHASE_WIDTH-1:0] voc_phase,
  output logic [PHASE_WIDTH-1:0] voc_last_phase,
  output logic [K_WIDTH-1:0]     voc_k_max,
  output logic                   voc_valid,
  input  logic [F_WIDTH-1:0]     voc_fundamental,
  input  logic                   voc_fundamental_valid,
  output logic [F_WIDTH-1:0]     fundamental,
  output logic                   fundamental_valid,
  output logic                   busy,
  input  logic                   clear_flags,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int unsigned CNT_W = cnt_width(max_u(RAM_LATENCY, VOC_LATENCY + 1));
  localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_LATENCY);
  // Loaded on leaving READ so it spans ISSUE plus the vocoder window.
  localparam logic [CNT_W-1:0] VOC_LOAD = CNT_W'(VOC_LATENCY + 1);

  frame_state_e state_q, state_d;

  logic                   primed_q, primed_d;
  logic                   wb_q, wb_d;
  logic [K_WIDTH-1:0]     k_q, k_d;
  logic [PHASE_WIDTH-1:0] vp_q, vp_d;
  logic [PHASE_WIDTH-1:0] vlp_q, vlp_d;
  logic [K_WIDTH-1:0]     vk_q, vk_d;
  logic [F_WIDTH-1:0]     fund_q, fund_d;
  logic                   fv_q, fv_d;
  logic                   ovr_q, ovr_d;
  logic                   to_q, to_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_tc;
  logic             start;
  logic             capture;
  logic             fund_hit;
  logic             to_hit;

  vocoder_frame_ctrl_cycle_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (cnt_count),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_done && primed_q) state_d = ST_READ;
      ST_READ:  if (cnt_tc) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (voc_fundamental_valid || cnt_tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    phase_rd_en = (state_q == ST_READ) && (cnt_count == RAM_LOAD);
    voc_valid   = (state_q == ST_ISSUE);
    start       = (state_q == ST_IDLE) && frame_done && primed_q;
    capture     = (state_q == ST_READ) && cnt_tc;
    fund_hit    = (state_q == ST_WAIT) && voc_fundamental_valid;
    to_hit      = (state_q == ST_WAIT) && cnt_tc && !voc_fundamental_valid;
    cnt_load    = start || capture;
    cnt_val     = capture ? VOC_LOAD : RAM_LOAD;
  end

  always_comb begin
    primed_d = primed_q;
    wb_d     = wb_q;
    k_d      = k_q;
    vp_d     = vp_q;
    vlp_d    = vlp_q;
    vk_d     = vk_q;
    fund_d   = fund_q;
    fv_d     = fund_hit;
    ovr_d    = ovr_q;
    to_d     = to_q;
    if ((state_q == ST_IDLE) && frame_done) begin
      wb_d     = ~wb_q;
      k_d      = frame_k_max;
      primed_d = 1'b1;
    end
    if (capture) begin
      vp_d  = cur_phase;
      vlp_d = last_phase_in;
      vk_d  = k_q;
    end
    if (fund_hit) begin
      fund_d = voc_fundamental;
    end
    // Clear first so a coincident set event wins.
    if (clear_flags) begin
      ovr_d = 1'b0;
      to_d  = 1'b0;
    end
    if (frame_done && busy) ovr_d = 1'b1;
    if (to_hit) to_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      primed_q <= 1'b0;
      wb_q     <= 1'b0;
      k_q      <= '0;
      vp_q     <= '0;
      vlp_q    <= '0;
      vk_q     <= '0;
      fund_q   <= '0;
      fv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      primed_q <= primed_d;
      wb_q     <= wb_d;
      k_q      <= k_d;
      vp_q     <= vp_d;
      vlp_q    <= vlp_d;
      vk_q     <= vk_d;
      fund_q   <= fund_d;
      fv_q     <= fv_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
    end
  end

  assign write_bank        = wb_q;
  assign phase_addr        = k_q;
  assign voc_phase         = vp_q;
  assign voc_last_phase    = vlp_q;
  assign voc_k_max         = vk_q;
  assign fundamental       = fund_q;
  assign fundamental_valid = fv_q;
  assign overrun           = ovr_q;
  assign timeout           = to_q;

endmodule
